ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/algol_pkg.sv | 5 +
 rtl/ram_arbiter.sv | 85 ++++++++
 2 files changed

// File: rtl/algol_pkg.sv
// algol_pkg: shared arbiter state encoding and grant encoding.
package algol_pkg;
   typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, ERR_I, ERR_D} state_e;
   typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_e;
endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving an instruction and a data master access to one RAM port.
// Define RAM_ARBITER_DECODE_EN to reject addresses outside the RAM region with an error response.
module ram_arbiter
   import algol_pkg::*;
#(
   parameter int          RAM_AW   = 20,
   parameter logic [31:0] RAM_BASE = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] iport_address,
   input  logic        iport_valid,
   output logic [31:0] iport_rdata,
   output logic        iport_ready,
   output logic        iport_error,
   input  logic [31:0] dport_address,
   input  logic [31:0] dport_wdata,
   input  logic [3:0]  dport_wsel,
   input  logic        dport_valid,
   output logic [31:0] dport_rdata,
   output logic        dport_ready,
   output logic        dport_error,
   output logic [31:0] ram_address,
   output logic [31:0] ram_wdata,
   output logic [3:0]  ram_wsel,
   output logic        ram_valid,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ready,
   input  logic        ram_error
);
`ifdef RAM_ARBITER_DECODE_EN
   localparam bit DECODE = 1'b1;
`else
   localparam bit DECODE = 1'b0;
`endif
   state_e state_q, state_d;
   grant_e last_q, last_d, pick;
   logic   err_ack_q, err_ack_d;
   logic   i_ok, d_ok, in_err;
   function automatic grant_e rr_pick(input logic iv, input logic dv, input grant_e last);
      return (iv && dv) ? ((last == GRANT_D) ? GRANT_I : GRANT_D) : (iv ? GRANT_I : GRANT_D);
   endfunction
   assign i_ok   = !DECODE || (iport_address[31:RAM_AW] == RAM_BASE[31:RAM_AW]);
   assign d_ok   = !DECODE || (dport_address[31:RAM_AW] == RAM_BASE[31:RAM_AW]);
   assign in_err = (state_q == ERR_I) || (state_q == ERR_D);
   assign pick   = rr_pick(iport_valid, dport_valid, last_q);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         last_q    <= GRANT_D;
         err_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         err_ack_q <= err_ack_d;
      end
   end
   // An error response spends one cycle in ERR_x before acknowledging, matching RAM latency.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      err_ack_d = in_err && !err_ack_q;
      case (state_q)
         IDLE: if (iport_valid || dport_valid) begin
            last_d  = pick;
            state_d = (pick == GRANT_I) ? (i_ok ? GNT_I : ERR_I) : (d_ok ? GNT_D : ERR_D);
         end
         GNT_I, GNT_D: state_d = ram_ready ? IDLE : state_q;
         ERR_I, ERR_D: state_d = err_ack_q ? IDLE : state_q;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      ram_valid   = (state_q == GNT_I) ? iport_valid : (state_q == GNT_D) ? dport_valid : 1'b0;
      ram_address = (state_q == GNT_D) ? dport_address : iport_address;
      ram_wdata   = dport_wdata;
      ram_wsel    = (state_q == GNT_D) ? dport_wsel : 4'b0;
      iport_rdata = (state_q == GNT_I) ? ram_rdata : 32'b0;
      iport_ready = ((state_q == GNT_I) && ram_ready) || ((state_q == ERR_I) && err_ack_q);
      iport_error = ((state_q == GNT_I) && ram_error) || ((state_q == ERR_I) && err_ack_q);
      dport_rdata = (state_q == GNT_D) ? ram_rdata : 32'b0;
      dport_ready = ((state_q == GNT_D) && ram_ready) || ((state_q == ERR_D) && err_ack_q);
      dport_error = ((state_q == GNT_D) && ram_error) || ((state_q == ERR_D) && err_ack_q);
   end
endmodule
